// File: rtl/hub75_panel_driver.sv
// HUB75 single-row driver: capture a row, shift it out MSB column first, blank, latch, then display.
// Optional build macro HUB75_DRIVER_OVERLAP_EN keeps the previous row lit through IDLE and SHIFT.
module hub75_panel_driver #(
    parameter int GL_NUM_COL_PIXELS = 32,
    parameter int CLK_DIV           = 2,
    parameter int LATCH_CYCLES      = 2,
    parameter int DISPLAY_CYCLES    = 1000
) (
    input  logic                           clk_in,
    input  logic                           reset_in,
    // Packed rgb_row_t: {top_r, top_g, top_b, bot_r, bot_g, bot_b}, GL_NUM_COL_PIXELS bits each
    input  logic [6*GL_NUM_COL_PIXELS-1:0] row_in,
    input  logic                           row_valid_in,
    output logic                           row_ready_out,
    input  logic [3:0]                     row_address_in,
    output logic                           r0_out,
    output logic                           g0_out,
    output logic                           b0_out,
    output logic                           r1_out,
    output logic                           g1_out,
    output logic                           b1_out,
    output logic                           panel_clk_out,
    output logic                           lat_out,
    output logic                           oe_n_out,
    output logic [3:0]                     addr_out
);

    localparam int N       = GL_NUM_COL_PIXELS;
    localparam int COLW    = $clog2(N + 1);
    localparam int IDXW    = (N > 1) ? $clog2(N) : 1;
    localparam int DIVW    = $clog2(2 * CLK_DIV + 1);
    localparam int CNT_MAX = (LATCH_CYCLES > DISPLAY_CYCLES) ? LATCH_CYCLES : DISPLAY_CYCLES;
    localparam int CNTW    = $clog2(CNT_MAX + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SHIFT   = 3'd1;
    localparam logic [2:0] S_BLANK   = 3'd2;
    localparam logic [2:0] S_LATCH   = 3'd3;
    localparam logic [2:0] S_DISPLAY = 3'd4;

    localparam logic [COLW-1:0] COL_FULL  = COLW'(N);
    localparam logic [COLW-1:0] COL_ONE   = COLW'(1);
    localparam logic [DIVW-1:0] DIV_ONE   = DIVW'(1);
    localparam logic [DIVW-1:0] DIV_HALF  = DIVW'(CLK_DIV);
    localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(2 * CLK_DIV - 1);
    localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);
    localparam logic [CNTW-1:0] LAT_LAST  = CNTW'(LATCH_CYCLES - 1);
    localparam logic [CNTW-1:0] DISP_LAST = CNTW'(DISPLAY_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [COLW-1:0]  col_q, col_d;
    logic [DIVW-1:0]  div_q, div_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [6*N-1:0]   hold_q, hold_d;
    logic [3:0]       haddr_q, haddr_d;

    logic             ready_q, ready_d;
    logic             pclk_q, pclk_d;
    logic             lat_q, lat_d;
    logic             oe_n_q, oe_n_d;
    logic [3:0]       addr_q, addr_d;
    logic [5:0]       data_q, data_d;

    logic [5:0][N-1:0] planes;
    logic [IDXW-1:0]   idx;

`ifdef HUB75_DRIVER_OVERLAP_EN
    logic shown_q, shown_d;
`endif

    // col counts columns still to send (N..1); the bit index is col-1
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        haddr_d = haddr_q;
        case (state_q)
            S_IDLE: begin
                if (row_valid_in) begin
                    hold_d  = row_in;
                    haddr_d = row_address_in;
                    col_d   = COL_FULL;
                    div_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (col_q == COL_ONE) begin
                        col_d   = '0;
                        state_d = S_BLANK;
                    end else begin
                        col_d = col_q - COL_ONE;
                    end
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end
            S_BLANK: begin
                cnt_d   = '0;
                state_d = S_LATCH;
            end
            S_LATCH: begin
                if (cnt_q == LAT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DISPLAY;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DISPLAY: begin
                if (cnt_q == DISP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign planes = hold_d;
    assign idx    = IDXW'(col_d - COL_ONE);

    // Outputs are registered from next-state values so they line up with state_q
    always_comb begin
        ready_d = (state_d == S_IDLE);
        pclk_d  = (state_d == S_SHIFT) && (div_d >= DIV_HALF);
        lat_d   = (state_d == S_LATCH);
        data_d  = data_q;
        if (state_d == S_SHIFT) begin
            data_d = {planes[5][idx], planes[4][idx], planes[3][idx],
                      planes[2][idx], planes[1][idx], planes[0][idx]};
        end
        addr_d = addr_q;
        if ((state_d == S_LATCH) && (state_q != S_LATCH)) begin
            addr_d = haddr_q;
        end
`ifdef HUB75_DRIVER_OVERLAP_EN
        shown_d = shown_q | (state_q == S_DISPLAY);
        oe_n_d  = 1'b1;
        if (state_d == S_DISPLAY) begin
            oe_n_d = 1'b0;
        end else if ((state_d == S_IDLE) || (state_d == S_SHIFT)) begin
            oe_n_d = ~shown_d;
        end
`else
        oe_n_d = (state_d != S_DISPLAY);
`endif
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            haddr_q <= '0;
            ready_q <= 1'b0;
            pclk_q  <= 1'b0;
            lat_q   <= 1'b0;
            oe_n_q  <= 1'b1;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            haddr_q <= haddr_d;
            ready_q <= ready_d;
            pclk_q  <= pclk_d;
            lat_q   <= lat_d;
            oe_n_q  <= oe_n_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

`ifdef HUB75_DRIVER_OVERLAP_EN
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            shown_q <= 1'b0;
        end else begin
            shown_q <= shown_d;
        end
    end
`endif

    assign row_ready_out = ready_q;
    assign panel_clk_out = pclk_q;
    assign lat_out       = lat_q;
    assign oe_n_out      = oe_n_q;
    assign addr_out      = addr_q;
    assign {r0_out, g0_out, b0_out, r1_out, g1_out, b1_out} = data_q;

    // The panel must never be lit while latching
    a_lat_dark: assert property (@(posedge clk_in) disable iff (reset_in) lat_q |-> oe_n_q);
    a_lat_state: assert property (@(posedge clk_in) disable iff (reset_in) lat_q |-> (state_q == S_LATCH));
    a_pclk_state: assert property (@(posedge clk_in) disable iff (reset_in) pclk_q |-> (state_q == S_SHIFT));
    a_ready_state: assert property (@(posedge clk_in) disable iff (reset_in) ready_q |-> (state_q == S_IDLE));

endmodule

// File: tb/tb_hub75_panel_driver.sv
// Randomized bench for hub75_panel_driver: a row-timeline model checks every output each cycle.
`timescale 1ns/1ps
module tb_hub75_panel_driver;
  localparam int N  = 32;
  localparam int CD = 2;
  localparam int LC = 2;
  localparam int DC = 40;
  localparam int S  = 2 * CD * N;           // shift cycles per row
  localparam int PERIOD = 172;              // 1 + 128 + 1 + 2 + 40
`ifdef HUB75_DRIVER_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_in = 1'b1;
  logic [6*N-1:0] row_in = '0;
  logic row_valid_in = 1'b1;
  logic row_ready_out;
  logic [3:0] row_address_in = 4'd0;
  logic r0_out, g0_out, b0_out, r1_out, g1_out, b1_out;
  logic panel_clk_out, lat_out, oe_n_out;
  logic [3:0] addr_out;

  hub75_panel_driver #(.GL_NUM_COL_PIXELS(N), .CLK_DIV(CD), .LATCH_CYCLES(LC), .DISPLAY_CYCLES(DC)) dut (
    .clk_in(clk), .reset_in(reset_in), .row_in(row_in), .row_valid_in(row_valid_in),
    .row_ready_out(row_ready_out), .row_address_in(row_address_in),
    .r0_out(r0_out), .g0_out(g0_out), .b0_out(b0_out), .r1_out(r1_out), .g1_out(g1_out), .b1_out(b1_out),
    .panel_clk_out(panel_clk_out), .lat_out(lat_out), .oe_n_out(oe_n_out), .addr_out(addr_out));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  function automatic logic getb(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic logic [6*N-1:0] rand_row();
    logic [6*N-1:0] r = '0;
    for (int i = 0; i < 6; i++) r = (r << 32) | (6*N)'($urandom);
    return r;
  endfunction

  // model: 0 = just reset, 1 = idle, 2 = busy (k = cycles since capture edge)
  int m_mode = 0;
  int m_k = 0;
  logic [5:0][N-1:0] m_hold = '0;
  logic [3:0] m_hadr = '0, m_addr = '0;
  logic [5:0] m_data = '0;
  bit m_shown = 1'b0;
  int phase;

  // observation counters (only this process writes them; stimulus reads deltas)
  int cyc = 0, rise_cnt = 0, lat_hi = 0, ready_hi = 0, cap_dut = 0;
  int oe_low = 0, oe_shift_low = 0, last_rdy = -1, rdy_gap = 0;
  logic [31:0] r0_acc = '0, b1_acc = '0;
  logic [3:0] addr_at_lat = '0;
  logic prev_pclk = 1'b0, prev_lat = 1'b0;

  initial begin
    logic e_ready, e_pclk, e_lat, e_oe;
    int bitn;
    @(posedge clk);
    forever begin
      @(negedge clk);
      cyc++;
      e_ready = 1'b0; e_pclk = 1'b0; e_lat = 1'b0; e_oe = 1'b1; phase = 0;
      if (m_mode == 1) begin
        phase = 1; e_ready = 1'b1; e_oe = OVL ? !m_shown : 1'b1;
      end else if (m_mode == 2) begin
        if (m_k < S) begin
          phase = 2;
          bitn = N - 1 - m_k / (2 * CD);
          e_pclk = (m_k % (2 * CD)) >= CD;
          m_data = {getb(m_hold[5], bitn), getb(m_hold[4], bitn), getb(m_hold[3], bitn),
                    getb(m_hold[2], bitn), getb(m_hold[1], bitn), getb(m_hold[0], bitn)};
          e_oe = OVL ? !m_shown : 1'b1;
        end else if (m_k == S) begin
          phase = 3;
        end else if (m_k < S + 1 + LC) begin
          phase = 4; e_lat = 1'b1; m_addr = m_hadr;
        end else begin
          phase = 5; e_oe = 1'b0;
        end
      end
      check("ready", 32'(row_ready_out), 32'(e_ready));
      check("panel_clk", 32'(panel_clk_out), 32'(e_pclk));
      check("lat", 32'(lat_out), 32'(e_lat));
      check("oe_n", 32'(oe_n_out), 32'(e_oe));
      check("addr", 32'(addr_out), 32'(m_addr));
      check("data", 32'({r0_out, g0_out, b0_out, r1_out, g1_out, b1_out}), 32'(m_data));

      if (!prev_pclk && panel_clk_out) begin
        rise_cnt++;
        r0_acc = {r0_acc[30:0], r0_out};
        b1_acc = {b1_acc[30:0], b1_out};
      end
      if (!prev_lat && lat_out) addr_at_lat = addr_out;
      if (lat_out) lat_hi++;
      if (!oe_n_out) oe_low++;
      if (phase == 2 && !oe_n_out) oe_shift_low++;
      if (row_ready_out) begin
        ready_hi++;
        if (last_rdy >= 0) rdy_gap = cyc - last_rdy;
        last_rdy = cyc;
        if (row_valid_in) cap_dut++;
      end
      prev_pclk = panel_clk_out;
      prev_lat = lat_out;

      if (reset_in) begin
        m_mode = 0; m_k = 0; m_hold = '0; m_hadr = '0; m_addr = '0; m_data = '0; m_shown = 1'b0;
      end else if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (row_valid_in) begin
          m_hold = row_in; m_hadr = row_address_in; m_mode = 2; m_k = 0;
        end
      end else begin
        if (m_k == S + LC + DC) begin
          m_mode = 1; m_shown = 1'b1;
        end else begin
          m_k++;
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle();
    int g = 0;
    while (!row_ready_out && g < 2000) begin tick(); g++; end
    if (!row_ready_out) timeout("wait_idle");
  endtask

  task automatic send_row(input logic [6*N-1:0] r, input logic [3:0] a);
    row_in = r; row_address_in = a; row_valid_in = 1'b1;
    wait_idle();
    tick();
    row_valid_in = 1'b0;
    row_in = rand_row();
    row_address_in = 4'($urandom);
  endtask

  initial begin
    int b_rise, b_lat, b_oes, b_rdy, b_cap, b_oe, g;
    logic [6*N-1:0] r28;
    row_in = rand_row();
    row_address_in = 4'd7;
    // reset held 3 cycles with valid high
    tick(3);
    check("rst_ready", 32'(row_ready_out), 32'd0);
    check("rst_oe_n", 32'(oe_n_out), 32'd1);
    check("rst_lat", 32'(lat_out), 32'd0);
    check("rst_pclk", 32'(panel_clk_out), 32'd0);
    check("rst_addr", 32'(addr_out), 32'd0);
    check("rst_data", 32'({r0_out, g0_out, b0_out, r1_out, g1_out, b1_out}), 32'd0);
    reset_in = 1'b0; row_valid_in = 1'b0;
    tick();
    check("ready_after_release", 32'(row_ready_out), 32'd1);

    // single known row, then the same row again for the overlap comparison
    r28 = {32'hA5A5_0F0F, 32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom), 32'h8000_0001};
    b_rise = rise_cnt; b_lat = lat_hi; b_oes = oe_shift_low;
    send_row(r28, 4'd9);
    tick(PERIOD);
    check("row_pclk_rises", 32'(rise_cnt - b_rise), 32'd32);
    check("row_r0_seq", r0_acc, 32'hA5A5_0F0F);
    check("row_b1_seq", b1_acc, 32'h8000_0001);
    check("row_addr_at_lat", 32'(addr_at_lat), 32'd9);
    check("row_lat_cycles", 32'(lat_hi - b_lat), 32'd2);
    check("first_row_oe_shift_low", 32'(oe_shift_low - b_oes), 32'd0);
    b_oes = oe_shift_low;
    send_row(r28, 4'd9);
    tick(PERIOD);
    check("second_row_oe_shift_low", 32'(oe_shift_low - b_oes), OVL ? 32'd128 : 32'd0);

    // valid held high, data churning every cycle
    wait_idle();
    b_rdy = ready_hi; b_cap = cap_dut;
    row_valid_in = 1'b1;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      row_in = rand_row(); row_address_in = 4'($urandom);
      tick();
    end
    row_valid_in = 1'b0;
    check("hs_ready_cycles", 32'(ready_hi - b_rdy), 32'd3);
    check("hs_captures", 32'(cap_dut - b_cap), 32'd3);
    check("hs_row_period", 32'(rdy_gap), 32'(PERIOD));

    // long stall
    wait_idle();
    tick();
    b_rise = rise_cnt; b_lat = lat_hi; b_rdy = ready_hi; b_oe = oe_low;
    tick(5000);
    check("stall_pclk_rises", 32'(rise_cnt - b_rise), 32'd0);
    check("stall_lat", 32'(lat_hi - b_lat), 32'd0);
    check("stall_ready", 32'(ready_hi - b_rdy), 32'd5000);
    check("stall_oe_low", 32'(oe_low - b_oe), OVL ? 32'd5000 : 32'd0);

    // reset during column 17 of SHIFT
    b_rise = rise_cnt;
    send_row(rand_row(), 4'($urandom));
    g = 0;
    while (rise_cnt - b_rise < 17 && g < 1000) begin tick(); g++; end
    if (rise_cnt - b_rise < 17) timeout("wait_col17");
    reset_in = 1'b1;
    tick();
    check("midrst_ready", 32'(row_ready_out), 32'd0);
    check("midrst_pclk", 32'(panel_clk_out), 32'd0);
    check("midrst_lat", 32'(lat_out), 32'd0);
    check("midrst_oe_n", 32'(oe_n_out), 32'd1);
    check("midrst_addr", 32'(addr_out), 32'd0);
    check("midrst_data", 32'({r0_out, g0_out, b0_out, r1_out, g1_out, b1_out}), 32'd0);
    b_lat = lat_hi;
    tick();
    reset_in = 1'b0;
    tick(200);
    check("midrst_no_latch", 32'(lat_hi - b_lat), 32'd0);
    b_rise = rise_cnt;
    send_row(rand_row(), 4'($urandom));
    tick(PERIOD);
    check("after_rst_rises", 32'(rise_cnt - b_rise), 32'd32);

    // random rows with random gaps
    for (int i = 0; i < 12; i++) begin
      tick($urandom_range(0, 5));
      send_row(rand_row(), 4'($urandom));
    end
    wait_idle();
    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/hub75_panel_driver.md
HUB75_PANEL_DRIVER -- requirements
Module: hub75_panel_driver

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: clk_in cycles per half period of panel_clk_out (legal 1..255).
REQ-002 SHALL have parameter LATCH_CYCLES, default 2: clk_in cycles lat_out is held high (legal >=1).
REQ-003 SHALL have parameter DISPLAY_CYCLES, default 1000: clk_in cycles oe_n_out is held low per row (legal >=1).
REQ-004 SHALL have ports: clk_in  in  1  system clock; one clock domain, all logic on its rising edge.
REQ-005 SHALL have port reset_in  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports: row_in  in  rgb_row_t  top/bot red/green/blue, GL_NUM_COL_PIXELS bits each; row_valid_in  in  1; row_ready_out  out  1; row_address_in  in  4.
REQ-007 SHALL have ports: r0_out g0_out b0_out r1_out g1_out b1_out  out  1 each  top (0) / bottom (1) half pixel data.
REQ-008 SHALL have ports: panel_clk_out  out  1  shift clock; lat_out  out  1  latch; oe_n_out  out  1  output enable, active-low; addr_out  out  4  panel row select.

Function
REQ-009 SHALL implement states IDLE, SHIFT, BLANK, LATCH, DISPLAY; every output registered.
REQ-010 IDLE: row_ready_out=1; on row_valid_in=1, SHALL capture row_in and row_address_in into holding registers, go to SHIFT, and drive row_ready_out=0 on the next cycle.
REQ-011 row_ready_out SHALL be 0 in every state except IDLE; row_valid_in outside IDLE SHALL be ignored and never alter the holding registers.
REQ-012 SHIFT: SHALL output GL_NUM_COL_PIXELS columns, index GL_NUM_COL_PIXELS-1 first, down to index 0.
REQ-013 Per column: data outputs SHALL change while panel_clk_out=0; panel_clk_out SHALL be 0 for CLK_DIV cycles and then 1 for CLK_DIV cycles; each column takes exactly 2*CLK_DIV cycles.
REQ-014 Column counter SHALL be $clog2(GL_NUM_COL_PIXELS+1) bits wide; after the last column's high phase, panel_clk_out SHALL return to 0 and the FSM SHALL go to BLANK.
REQ-015 BLANK: oe_n_out=1 for exactly 1 cycle, then go to LATCH.
REQ-016 LATCH: addr_out SHALL load the captured address on LATCH entry; lat_out=1 for LATCH_CYCLES cycles, oe_n_out=1, then go to DISPLAY.
REQ-017 DISPLAY: oe_n_out=0 for DISPLAY_CYCLES cycles, lat_out=0, then go to IDLE.
REQ-018 addr_out SHALL hold its value in all other states; data outputs SHALL hold the last shifted column outside SHIFT.
REQ-019 Row period SHALL be 1 (IDLE accept) + 2*CLK_DIV*GL_NUM_COL_PIXELS + 1 + LATCH_CYCLES + DISPLAY_CYCLES cycles when row_valid_in is already high in IDLE.
REQ-020 When row_valid_in stays low, the FSM SHALL remain in IDLE indefinitely with oe_n_out=1 (unless REQ-025 applies) and all other outputs stable.

Reset
REQ-021 While reset_in=1 at a clock edge: state=IDLE, row_ready_out=0, panel_clk_out=0, lat_out=0, oe_n_out=1, addr_out=0, all six data outputs=0, counters=0, holding registers=0.
REQ-022 First cycle after reset_in falls, row_ready_out SHALL be 1.
REQ-023 Reset asserted in any state, including mid-SHIFT or mid-DISPLAY, SHALL abort the row with no partial latch pulse after reset takes effect.

Configuration
REQ-024 Macro HUB75_DRIVER_OVERLAP_EN SHALL select the display-overlap feature.
REQ-025 Defined: oe_n_out SHALL stay low through IDLE and SHIFT while the previous row is displayed, and go high only in BLANK and LATCH; oe_n_out SHALL remain high until the first DISPLAY after reset.
REQ-026 Undefined: oe_n_out SHALL be 1 in IDLE, SHIFT, BLANK and LATCH, and 0 only in DISPLAY.

Verification
REQ-027 Reset: hold reset_in 3 cycles with row_valid_in=1 -> outputs per REQ-021 and no capture; row_ready_out=1 on the first cycle after release.
REQ-028 Single row: CLK_DIV=2, top.red=32'hA5A5_0F0F, bot.blue=32'h8000_0001, address 4'd9 -> 32 panel_clk_out rising edges, sampled r0_out sequence MSB-first equals A5A50F0F, b1_out equals 80000001, addr_out=9 at lat_out rise, lat_out high 2 cycles.
REQ-029 Handshake: row_valid_in held high continuously -> exactly one capture per row period (REQ-019 count), row_ready_out high exactly 1 cycle per row; an input change during SHIFT does not affect the shifted data.
REQ-030 Stall: no row_valid_in for 5000 cycles after a row -> IDLE held, panel_clk_out=0, lat_out=0, oe_n_out per the macro setting.
REQ-031 Mid-row reset: assert reset_in at column 17 of SHIFT -> next-cycle outputs per REQ-021; the next row after release shifts a full 32 columns.
REQ-032 Macro: run REQ-028 with and without HUB75_DRIVER_OVERLAP_EN -> oe_n_out low during the second row's SHIFT only when the macro is defined; high in BLANK/LATCH in both builds.
